can_ifc_wb_wide: RTL and testbench

CAN_IFC_WB_WIDE -- requirements
Module: can_ifc_wb_wide

---
 rtl/can_ifc_wb_wide.sv | 176 +++++++++++++++++
 tb/tb_can_ifc_wb_wide.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_ifc_wb_wide.sv
// rtl/can_ifc_wb_wide.sv - Wishbone slave bridging DW-wide transfers onto a byte-wide register bus
module can_ifc_wb_wide #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            reg_rst_o,
    output logic            reg_re_o,
    output logic            reg_we_o,
    output logic [7:0]      reg_addr_o,
    output logic [7:0]      reg_data_in_o,
    input  logic [7:0]      reg_data_out_i
);

    localparam int NL = DW / 8;
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic [7:0]      adr_q;
    logic [DW-1:0]   dat_q;
    logic            we_q;
    logic            abort_q;
    logic [NL-1:0]   mask_q;
    logic [LW-1:0]   cur_lane_q;
    logic [1:0]      wait_cnt_q;

    logic [LW-1:0]   lane_idx;
    logic [LW-1:0]   sample_lane;
    logic [NL-1:0]   lane_onehot;
    logic [7:0]      lane_addr;
    logic            accept;
    logic            issue;
    logic            sample;
    logic            abort;

    assign reg_rst_o = rst_i;

    // Lowest-index pending lane is always serviced first.
    always_comb begin
        lane_idx = '0;
        for (int i = NL - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                lane_idx = LW'(i);
            end
        end
    end

    assign lane_onehot = NL'(1) << lane_idx;
    assign lane_addr   = (adr_q & ~8'(NL - 1)) | 8'(lane_idx);
    assign sample_lane = (state_q == ISSUE) ? lane_idx : cur_lane_q;
    assign abort       = abort_q | ~wb_cyc_i;

    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        issue     = 1'b0;
        sample    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    accept    = 1'b1;
                    state_nxt = (wb_sel_i == '0) ? ACK : ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (!we_q && RD_LAT != 0) begin
                    state_nxt = WAIT;
                end else begin
                    sample = ~we_q;
                    if (abort) begin
                        state_nxt = IDLE;
                    end else if ((mask_q & ~lane_onehot) != '0) begin
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = ACK;
                    end
                end
            end
            WAIT: begin
                // A dropped cycle still lets the outstanding byte finish its wait.
                if (wait_cnt_q == 2'd0) begin
                    sample = 1'b1;
                    if (abort) begin
                        state_nxt = IDLE;
                    end else if (mask_q != '0) begin
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        wb_ack_o      = (state_q == ACK);
        reg_re_o      = issue & ~we_q;
        reg_we_o      = issue & we_q;
        reg_addr_o    = 8'h00;
        reg_data_in_o = 8'h00;
        if (issue) begin
            reg_addr_o = lane_addr;
            if (we_q) begin
                reg_data_in_o = dat_q[8*int'(lane_idx) +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            adr_q      <= 8'h00;
            dat_q      <= '0;
            we_q       <= 1'b0;
            abort_q    <= 1'b0;
            mask_q     <= '0;
            cur_lane_q <= '0;
            wait_cnt_q <= 2'd0;
            wb_dat_o   <= '0;
        end else if (accept) begin
            adr_q    <= wb_adr_i[7:0];
            dat_q    <= wb_dat_i;
            we_q     <= wb_we_i;
            mask_q   <= wb_sel_i;
            abort_q  <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            if (issue) begin
                mask_q     <= mask_q & ~lane_onehot;
                cur_lane_q <= lane_idx;
                wait_cnt_q <= 2'(RD_LAT - 1);
            end
            if (state_q == WAIT && wait_cnt_q != 2'd0) begin
                wait_cnt_q <= wait_cnt_q - 2'd1;
            end
            if (sample) begin
                wb_dat_o[8*int'(sample_lane) +: 8] <= reg_data_out_i;
            end
            if ((state_q == ISSUE || state_q == WAIT) && !wb_cyc_i) begin
                abort_q <= 1'b1;
            end
            // Lanes left behind by an abandoned cycle must not leak into the next one.
            if (state_nxt == IDLE) begin
                mask_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_can_ifc_wb_wide.sv
// tb/tb_can_ifc_wb_wide.sv - self-checking bench for can_ifc_wb_wide
module tb_can_ifc_wb_wide;

    localparam int LAT_A = 1;
    localparam int NT    = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [7:0]  adr = 8'h00;
    logic [31:0] dat = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic [1:0]  sel_c = 2'b00;
    logic        cyc_a = 1'b0, cyc_b = 1'b0, cyc_c = 1'b0;

    logic [31:0] dat_o_a, dat_o_b;
    logic [15:0] dat_o_c;
    logic        ack_a, ack_b, ack_c, rrst_a, rrst_b, rrst_c;
    logic        re_a, re_b, re_c, we_a, we_b, we_c;
    logic [7:0]  addr_a, addr_b, addr_c, din_a, din_b, din_c;
    logic [7:0]  dout_a, dout_b, dout_c;

    can_ifc_wb_wide #(.DW(32), .AW(8), .RD_LAT(1)) u_a (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat_o_a), .wb_ack_o(ack_a),
        .reg_rst_o(rrst_a), .reg_re_o(re_a), .reg_we_o(we_a), .reg_addr_o(addr_a),
        .reg_data_in_o(din_a), .reg_data_out_i(dout_a));

    can_ifc_wb_wide #(.DW(32), .AW(8), .RD_LAT(2)) u_b (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat_o_b), .wb_ack_o(ack_b),
        .reg_rst_o(rrst_b), .reg_re_o(re_b), .reg_we_o(we_b), .reg_addr_o(addr_b),
        .reg_data_in_o(din_b), .reg_data_out_i(dout_b));

    can_ifc_wb_wide #(.DW(16), .AW(8), .RD_LAT(0)) u_c (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc_c), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel_c), .wb_dat_i(dat[15:0]), .wb_dat_o(dat_o_c), .wb_ack_o(ack_c),
        .reg_rst_o(rrst_c), .reg_re_o(re_c), .reg_we_o(we_c), .reg_addr_o(addr_c),
        .reg_data_in_o(din_c), .reg_data_out_i(dout_c));

    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    // Register files seen by each bridge; contents reload to i^A5 while reset is high.
    logic [7:0] ram_a [256];
    logic [7:0] ram_b [256];
    logic [7:0] ram_c [256];
    logic [7:0] pa = 8'h00, pb0 = 8'h00, pb1 = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                ram_a[i] <= 8'(i) ^ 8'hA5;
                ram_b[i] <= 8'(i) ^ 8'hA5;
                ram_c[i] <= 8'(i) ^ 8'hA5;
            end
        end else begin
            if (we_a) ram_a[addr_a] <= din_a;
            if (we_b) ram_b[addr_b] <= din_b;
            if (we_c) ram_c[addr_c] <= din_c;
        end
        if (re_a) pa <= addr_a;
        if (re_b) pb0 <= addr_b;
        pb1 <= pb0;
    end

    assign dout_a = ram_a[pa];
    assign dout_b = ram_b[pb1];
    assign dout_c = ram_c[addr_c];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cnt, act, exp);
        end
    endtask

    // Transaction-level model for u_a: a per-cycle schedule of strobes and acks.
    bit         e_re [NT];
    bit         e_we [NT];
    bit         e_ack[NT];
    bit [7:0]   e_addr[NT];
    bit [7:0]   e_din [NT];
    bit [31:0]  e_dat [NT];
    logic [7:0] mem_a [256];

    task automatic model_init();
        for (int i = 0; i < 256; i++) mem_a[i] = 8'(i) ^ 8'hA5;
    endtask

    task automatic plan_a(input int base, input bit w, input logic [7:0] a, input logic [3:0] s,
                          input logic [31:0] d, output int ack_c);
        int c;
        logic [7:0] ad;
        logic [31:0] rd;
        c  = base + 1;
        rd = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (s[k]) begin
                ad = (a & 8'hFC) + 8'(k);
                e_addr[c] = ad;
                if (w) begin
                    e_we[c]   = 1'b1;
                    e_din[c]  = d[8*k +: 8];
                    mem_a[ad] = d[8*k +: 8];
                    c = c + 1;
                end else begin
                    e_re[c] = 1'b1;
                    rd[8*k +: 8] = mem_a[ad];
                    c = c + 1 + LAT_A;
                end
            end
        end
        e_ack[c] = 1'b1;
        e_dat[c] = rd;
        ack_c = c;
    endtask

    int          we_a_n = 0, last_ack_a_cnt = 0;
    logic [31:0] last_dat_a = 32'h0;
    int          re_b_n = 0, ack_b_n = 0, last_re_b_cnt = 0, last_ack_b_cnt = 0;
    logic [7:0]  last_re_b_addr = 8'h00;
    logic [31:0] last_ack_b_dat = 32'h0;
    int          re_c_n = 0, we_c_n = 0, ack_c_n = 0, last_re_c_cnt = 0, last_ack_c_cnt = 0;
    logic [7:0]  last_re_c_addr = 8'h00;
    logic [15:0] last_ack_c_dat = 16'h0;

    always @(negedge clk) begin
        if (!rst && cnt < NT) begin
            chk("re_a", re_a, e_re[cnt]);
            chk("we_a", we_a, e_we[cnt]);
            chk("ack_a", ack_a, e_ack[cnt]);
            if (e_re[cnt] || e_we[cnt]) chk("addr_a", addr_a, e_addr[cnt]);
            if (e_we[cnt]) chk("din_a", din_a, e_din[cnt]);
            if (e_ack[cnt]) chk("dat_a", dat_o_a, e_dat[cnt]);
            chk("excl_b", re_b & we_b, 0);
            chk("excl_c", re_c & we_c, 0);
            if (we_a) we_a_n++;
            if (ack_a) begin last_ack_a_cnt = cnt; last_dat_a = dat_o_a; end
            if (re_b) begin re_b_n++; last_re_b_cnt = cnt; last_re_b_addr = addr_b; end
            if (ack_b) begin ack_b_n++; last_ack_b_cnt = cnt; last_ack_b_dat = dat_o_b; end
            if (re_c) begin re_c_n++; last_re_c_cnt = cnt; last_re_c_addr = addr_c; end
            if (we_c) we_c_n++;
            if (ack_c) begin ack_c_n++; last_ack_c_cnt = cnt; last_ack_c_dat = dat_o_c; end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic xfer_a(input bit w, input logic [7:0] a, input logic [3:0] s, input logic [31:0] d,
                          input bit hold, output int base, output int ack_c);
        step(1);
        cyc_a = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        base = cnt;
        plan_a(base, w, a, s, d, ack_c);
        while (cnt < ack_c) step(1);
        if (!hold) begin
            step(1);
            cyc_a = 1'b0; stb = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int b, ac, s, w0, r0, k0;
        model_init();
        #2;
        chk("rst_dat_a", dat_o_a, 0);
        chk("rst_ack_a", ack_a, 0);
        chk("rst_re_a", re_a, 0);
        chk("rst_we_a", we_a, 0);
        chk("rst_addr_a", addr_a, 0);
        chk("rst_din_a", din_a, 0);
        chk("rst_rrst_a", rrst_a, 1);
        chk("rst_rrst_c", rrst_c, 1);
        step(3);
        rst = 1'b0;
        #1 chk("rrst_low", rrst_a, 0);

        // Full-word write, lanes issued low to high.
        xfer_a(1'b1, 8'h10, 4'hF, 32'hA1B2C3D4, 1'b0, b, ac);
        chk("lat36_model", ac - b, 5);
        chk("lat36_dut", last_ack_a_cnt - b, 5);
        chk("ram10", ram_a[8'h10], 8'hD4);
        chk("ram11", ram_a[8'h11], 8'hC3);
        chk("ram12", ram_a[8'h12], 8'hB2);
        chk("ram13", ram_a[8'h13], 8'hA1);

        // Back-to-back with strobe held across each ack.
        xfer_a(1'b1, 8'h20, 4'b0101, 32'h00330011, 1'b1, b, ac);
        xfer_a(1'b1, 8'h34, 4'b1010, 32'h11223344, 1'b1, b, ac);
        xfer_a(1'b0, 8'h20, 4'b0101, 32'h0, 1'b0, b, ac);
        chk("lat37", last_ack_a_cnt - b, 5);
        chk("dat37", last_dat_a, 32'h00330011);
        xfer_a(1'b0, 8'h34, 4'hF, 32'h0, 1'b0, b, ac);
        chk("dat_mixed", last_dat_a, 32'h11933391);
        chk("lat_read4", last_ack_a_cnt - b, 9);
        xfer_a(1'b0, 8'h40, 4'h0, 32'h0, 1'b0, b, ac);
        chk("lat_sel0", last_ack_a_cnt - b, 1);

        // Reset asserted while the third lane of a write is on the bus.
        step(1);
        cyc_a = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h50; sel = 4'hF; dat = 32'h01020304;
        b = cnt; w0 = we_a_n;
        plan_a(b, 1'b1, 8'h50, 4'hF, 32'h01020304, ac);
        while (cnt < b + 3) step(1);
        for (int c = b + 3; c <= ac; c++) begin
            e_we[c] = 1'b0; e_re[c] = 1'b0; e_ack[c] = 1'b0;
        end
        chk("pre40_we", we_a, 1);
        rst = 1'b1;
        #1;
        chk("rst40_we", we_a, 0);
        chk("rst40_re", re_a, 0);
        chk("rst40_addr", addr_a, 0);
        chk("rst40_din", din_a, 0);
        chk("rst40_dat", dat_o_a, 0);
        chk("rst40_rrst", rrst_a, 1);
        cyc_a = 1'b0; stb = 1'b0;
        step(1);
        rst = 1'b0;
        model_init();
        step(4);
        chk("we_cnt40", we_a_n - w0, 2);
        xfer_a(1'b0, 8'h50, 4'b0011, 32'h0, 1'b0, b, ac);
        chk("dat_after_rst", last_dat_a, 32'h0000F4F5);

        // RD_LAT=2 read abandoned during its first wait cycle.
        step(1);
        cyc_b = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h40; sel = 4'hF;
        s = cnt; r0 = re_b_n; k0 = ack_b_n;
        step(2);
        cyc_b = 1'b0; stb = 1'b0;
        step(2);
        chk("re_cnt39", re_b_n - r0, 1);
        chk("re_addr39", last_re_b_addr, 8'h40);
        chk("re_cyc39", last_re_b_cnt - s, 1);
        chk("ack39", ack_b_n - k0, 0);
        cyc_b = 1'b1; stb = 1'b1; adr = 8'h44; sel = 4'h1;
        step(5);
        cyc_b = 1'b0; stb = 1'b0;
        chk("re_cnt39b", re_b_n - r0, 2);
        chk("re_cyc39b", last_re_b_cnt - s, 5);
        chk("re_addr39b", last_re_b_addr, 8'h44);
        chk("ack_cyc39b", last_ack_b_cnt - s, 8);
        chk("dat39b", last_ack_b_dat, 32'h000000E1);

        // DW=16: empty select write, then RD_LAT=0 reads.
        step(1);
        cyc_c = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h60; sel_c = 2'b00; dat = 32'h0000BEEF;
        s = cnt; w0 = we_c_n; k0 = ack_c_n;
        step(2);
        cyc_c = 1'b0; stb = 1'b0;
        step(1);
        chk("we38", we_c_n - w0, 0);
        chk("ack_n38", ack_c_n - k0, 1);
        chk("ack_cyc38", last_ack_c_cnt - s, 1);

        step(1);
        cyc_c = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h30; sel_c = 2'b11;
        s = cnt; r0 = re_c_n;
        step(4);
        cyc_c = 1'b0; stb = 1'b0;
        chk("re_n_c", re_c_n - r0, 2);
        chk("re_last_c", last_re_c_cnt - s, 2);
        chk("re_addr_c", last_re_c_addr, 8'h31);
        chk("ack_cyc_c", last_ack_c_cnt - s, 3);
        chk("dat_c", last_ack_c_dat, 16'h9495);

        step(1);
        cyc_c = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h32; sel_c = 2'b10;
        s = cnt; r0 = re_c_n;
        step(3);
        cyc_c = 1'b0; stb = 1'b0;
        chk("re_n_c2", re_c_n - r0, 1);
        chk("re_addr_c2", last_re_c_addr, 8'h33);
        chk("ack_cyc_c2", last_ack_c_cnt - s, 2);
        chk("dat_c2", last_ack_c_dat, 16'h9600);

        step(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
